// File: rtl/iomem_periph_pkg.sv
// Shared definitions for the iomem peripheral bank: register offsets,
// the voice register layout and a byte-lane mask helper.
package iomem_periph_pkg;

    localparam logic [7:0] OFF_GPIO       = 8'h00;
    localparam logic [7:0] OFF_BTN_STATE  = 8'h04;
    localparam logic [7:0] OFF_BTN_EVENT  = 8'h08;
    localparam logic [7:0] OFF_BTN_IRQ_EN = 8'h0C;
    localparam logic [7:0] OFF_VOICE_BASE = 8'h40;

    localparam int PITCH_LSB = 0;
    localparam int PITCH_W   = 8;
    localparam int VEL_LSB   = 8;
    localparam int VEL_W     = 8;
    localparam int WAVE_LSB  = 16;
    localparam int WAVE_W    = 2;
    localparam int GATE_LSB  = 24;

    localparam int REL_EVT_LSB = 16;

    typedef struct packed {
        logic              gate;
        logic [WAVE_W-1:0]  waveform;
        logic [VEL_W-1:0]   velocity;
        logic [PITCH_W-1:0] pitch;
    } voice_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

    function automatic logic [31:0] voice_to_word(input voice_t v);
        logic [31:0] w;
        w = '0;
        w[PITCH_LSB +: PITCH_W] = v.pitch;
        w[VEL_LSB +: VEL_W]     = v.velocity;
        w[WAVE_LSB +: WAVE_W]   = v.waveform;
        w[GATE_LSB]             = v.gate;
        return w;
    endfunction

    function automatic voice_t word_to_voice(input logic [31:0] w);
        voice_t v;
        v.pitch    = w[PITCH_LSB +: PITCH_W];
        v.velocity = w[VEL_LSB +: VEL_W];
        v.waveform = w[WAVE_LSB +: WAVE_W];
        v.gate     = w[GATE_LSB];
        return v;
    endfunction

endpackage

// File: rtl/iomem_periph_bank_btn_debounce.sv
// Per-bit button debouncer: 2-flop synchroniser, hold counter and stable
// level, with single-cycle rise/fall pulses coincident with the level update.
module btn_debounce #(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]            sync1_q, sync2_q;
    logic [W-1:0]            stable_q, stable_d;
    logic [W-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise     = '0;
        fall     = '0;
        for (int i = 0; i < W; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                rise[i]     = sync2_q[i];
                fall[i]     = !sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/iomem_periph_bank.sv
// PicoSoC iomem slave with GPIO, debounced buttons (sticky events + irq) and synth
// voice registers. Define BTN_RELEASE_EVT_EN to add release events at bit 16 upward.
module iomem_periph_bank
    import iomem_periph_pkg::*;
#(
    parameter logic [7:0] BASE_PAGE       = 8'h03,
    parameter int         GPIO_W          = 8,
    parameter int         BTN_W           = 4,
    parameter int         NUM_VOICES      = 4,
    parameter int         DEBOUNCE_CYCLES = 12000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    iomem_valid,
    output logic                    iomem_ready,
    input  logic [3:0]              iomem_wstrb,
    input  logic [31:0]             iomem_addr,
    input  logic [31:0]             iomem_wdata,
    output logic [31:0]             iomem_rdata,
    input  logic [BTN_W-1:0]        btn_in,
    output logic [GPIO_W-1:0]       gpio_out,
    output logic                    irq,
    output logic [8*NUM_VOICES-1:0] voice_pitch,
    output logic [8*NUM_VOICES-1:0] voice_velocity,
    output logic [2*NUM_VOICES-1:0] voice_waveform,
    output logic [NUM_VOICES-1:0]   voice_gate
);

    localparam logic [31:0] LVL_MASK = 32'((64'd1 << BTN_W) - 64'd1);
`ifdef BTN_RELEASE_EVT_EN
    localparam logic [31:0] EVT_MASK = LVL_MASK | (LVL_MASK << REL_EVT_LSB);
`else
    localparam logic [31:0] EVT_MASK = LVL_MASK;
`endif

    logic                         ready_q, ready_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic [GPIO_W-1:0]            gpio_q, gpio_d;
    logic [31:0]                  evt_q, evt_d;
    logic [31:0]                  irq_en_q, irq_en_d;
    voice_t [NUM_VOICES-1:0]      voice_q, voice_d;

    logic [BTN_W-1:0] btn_stable, btn_rise, btn_fall;
    logic             sel, wr, voice_hit;
    logic [7:0]       off, voice_off;
    logic [3:0]       voice_idx;
    logic [31:0]      wmask, evt_set, evt_clr;
    logic             unused_bits;

    btn_debounce #(
        .W               (BTN_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .resetn (resetn),
        .din    (btn_in),
        .stable (btn_stable),
        .rise   (btn_rise),
        .fall   (btn_fall)
    );

    // A held request is answered once; the cycle after ready never re-selects.
    assign sel       = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_PAGE);
    assign wr        = sel && (iomem_wstrb != 4'b0000);
    assign off       = {iomem_addr[7:2], 2'b00};
    assign wmask     = lane_mask(iomem_wstrb);
    assign voice_off = off - OFF_VOICE_BASE;
    assign voice_idx = voice_off[5:2];
    assign voice_hit = (off >= OFF_VOICE_BASE) && (int'(voice_off) < 4 * NUM_VOICES);

    always_comb begin
        evt_set = 32'(btn_rise);
`ifdef BTN_RELEASE_EVT_EN
        evt_set = evt_set | (32'(btn_fall) << REL_EVT_LSB);
`endif
    end

    assign evt_clr = (wr && off == OFF_BTN_EVENT) ? (iomem_wdata & wmask) : '0;

    always_comb begin
        ready_d  = sel;
        rdata_d  = '0;
        gpio_d   = gpio_q;
        irq_en_d = irq_en_q;
        voice_d  = voice_q;
        // Set is applied after clear so a coincident edge is never lost.
        evt_d    = ((evt_q & ~evt_clr) | evt_set) & EVT_MASK;

        if (sel) begin
            case (off)
                OFF_GPIO:       rdata_d = 32'(gpio_q);
                OFF_BTN_STATE:  rdata_d = 32'(btn_stable);
                OFF_BTN_EVENT:  rdata_d = evt_q;
                OFF_BTN_IRQ_EN: rdata_d = irq_en_q;
                default:        rdata_d = '0;
            endcase
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_hit && voice_idx == v[3:0]) begin
                    rdata_d = voice_to_word(voice_q[v]);
                end
            end
        end

        if (wr) begin
            if (off == OFF_GPIO) begin
                gpio_d = GPIO_W'((32'(gpio_q) & ~wmask) | (iomem_wdata & wmask));
            end
            if (off == OFF_BTN_IRQ_EN) begin
                irq_en_d = ((irq_en_q & ~wmask) | (iomem_wdata & wmask)) & EVT_MASK;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_hit && voice_idx == v[3:0]) begin
                    voice_d[v] = word_to_voice((voice_to_word(voice_q[v]) & ~wmask)
                                               | (iomem_wdata & wmask));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            gpio_q   <= '0;
            evt_q    <= '0;
            irq_en_q <= '0;
            voice_q  <= '0;
        end else begin
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            gpio_q   <= gpio_d;
            evt_q    <= evt_d;
            irq_en_q <= irq_en_d;
            voice_q  <= voice_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign gpio_out    = gpio_q;
    assign irq         = |(evt_q & irq_en_q);

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign voice_pitch[8*v +: 8]    = voice_q[v].pitch;
        assign voice_velocity[8*v +: 8] = voice_q[v].velocity;
        assign voice_waveform[2*v +: 2] = voice_q[v].waveform;
        assign voice_gate[v]            = voice_q[v].gate;
    end

    assign unused_bits = ^{iomem_addr[23:8], iomem_addr[1:0], voice_off[7:6], btn_fall};

endmodule

// File: tb/tb_iomem_periph_bank.sv
// Bench for iomem_periph_bank with a short debounce window.
module tb_iomem_periph_bank;

    localparam int GPIO_W     = 8;
    localparam int BTN_W      = 4;
    localparam int NUM_VOICES = 4;
    localparam int DEB        = 4;
`ifdef BTN_RELEASE_EVT_EN
    localparam logic [31:0] EN_ALL  = 32'h000F000F;
    localparam logic [31:0] REL_EVT = 32'h00020000;
`else
    localparam logic [31:0] EN_ALL  = 32'h0000000F;
    localparam logic [31:0] REL_EVT = 32'h00000000;
`endif

    logic                    clk;
    logic                    resetn;
    logic                    iomem_valid;
    logic                    iomem_ready;
    logic [3:0]              iomem_wstrb;
    logic [31:0]             iomem_addr;
    logic [31:0]             iomem_wdata;
    logic [31:0]             iomem_rdata;
    logic [BTN_W-1:0]        btn_in;
    logic [GPIO_W-1:0]       gpio_out;
    logic                    irq;
    logic [8*NUM_VOICES-1:0] voice_pitch;
    logic [8*NUM_VOICES-1:0] voice_velocity;
    logic [2*NUM_VOICES-1:0] voice_waveform;
    logic [NUM_VOICES-1:0]   voice_gate;

    iomem_periph_bank #(
        .BASE_PAGE       (8'h03),
        .GPIO_W          (GPIO_W),
        .BTN_W           (BTN_W),
        .NUM_VOICES      (NUM_VOICES),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .iomem_valid    (iomem_valid),
        .iomem_ready    (iomem_ready),
        .iomem_wstrb    (iomem_wstrb),
        .iomem_addr     (iomem_addr),
        .iomem_wdata    (iomem_wdata),
        .iomem_rdata    (iomem_rdata),
        .btn_in         (btn_in),
        .gpio_out       (gpio_out),
        .irq            (irq),
        .voice_pitch    (voice_pitch),
        .voice_velocity (voice_velocity),
        .voice_waveform (voice_waveform),
        .voice_gate     (voice_gate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_gpio;
        logic [31:0] exp_v2;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [31:0] r,
                           input logic [7:0] g, input logic [31:0] v2);
        vec_t t;
        t.name = n; t.addr = a; t.wstrb = s; t.wdata = d;
        t.exp_rd = r; t.exp_gpio = g; t.exp_v2 = v2;
        vq.push_back(t);
    endtask

    function automatic logic [31:0] v2_word();
        return {7'b0, voice_gate[2], 6'b0, voice_waveform[5:4],
                voice_velocity[23:16], voice_pitch[23:16]};
    endfunction

    // One bus transaction: expected read data is queued at issue, checked at ready.
    task automatic bus_xfer(input string n, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d, input logic [31:0] exp_rd);
        int          waited;
        logic [31:0] e;
        waited = 0;
        exp_q.push_back(exp_rd);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        @(posedge clk); #1;
        while (!iomem_ready && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({n, "_latency"}, 32'(waited), 32'd0);
        e = exp_q.pop_front();
        chk({n, "_rdata"}, iomem_rdata, e);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        @(posedge clk); #1;
        chk({n, "_ready_drop"}, 32'(iomem_ready), 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    int n;
    int ready_cnt;

    initial begin
        resetn      = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        btn_in      = '0;

        // Reset
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("rst_gpio", 32'(gpio_out), 32'h0);
        chk("rst_pitch", voice_pitch, 32'h0);
        chk("rst_velocity", voice_velocity, 32'h0);
        chk("rst_wave_gate", {20'h0, voice_waveform, voice_gate}, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_ready", 32'(iomem_ready), 32'h0);
        chk("rst_rdata", iomem_rdata, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Register access table
        add_vec("gpio_wr",      32'h03000000, 4'b0001, 32'h000000A5, 32'h00000000, 8'hA5, 32'h00000000);
        add_vec("gpio_rd",      32'h03000000, 4'b0000, 32'h00000000, 32'h000000A5, 8'hA5, 32'h00000000);
        add_vec("gpio_hi_lane", 32'h03000000, 4'b0010, 32'hFFFF1234, 32'h000000A5, 8'hA5, 32'h00000000);
        add_vec("v2_wr",        32'h03000048, 4'b1111, 32'h01024064, 32'h00000000, 8'hA5, 32'h01024064);
        add_vec("v2_vel",       32'h03000048, 4'b0010, 32'h00007F00, 32'h01024064, 8'hA5, 32'h01027F64);
        add_vec("v2_rd_alias",  32'h03ABCD4B, 4'b0000, 32'h00000000, 32'h01027F64, 8'hA5, 32'h01027F64);
        add_vec("v2_wave_lane", 32'h03000048, 4'b0100, 32'hFFFFFFFF, 32'h01027F64, 8'hA5, 32'h01037F64);
        add_vec("v2_gate_clr",  32'h03000048, 4'b1000, 32'hFE000000, 32'h01037F64, 8'hA5, 32'h00037F64);
        add_vec("v2_gate_set",  32'h03000048, 4'b1000, 32'h01000000, 32'h00037F64, 8'hA5, 32'h01037F64);
        add_vec("unused_rd",    32'h03000010, 4'b0000, 32'h00000000, 32'h00000000, 8'hA5, 32'h01037F64);
        add_vec("v0_wr",        32'h03000040, 4'b0001, 32'h0000005A, 32'h00000000, 8'hA5, 32'h01037F64);
        add_vec("v0_rd",        32'h03000040, 4'b0000, 32'h00000000, 32'h0000005A, 8'hA5, 32'h01037F64);
        add_vec("v4_wr",        32'h03000050, 4'b1111, 32'hFFFFFFFF, 32'h00000000, 8'hA5, 32'h01037F64);
        add_vec("v4_rd",        32'h03000050, 4'b0000, 32'h00000000, 32'h00000000, 8'hA5, 32'h01037F64);
        add_vec("state_wr",     32'h03000004, 4'b1111, 32'hFFFFFFFF, 32'h00000000, 8'hA5, 32'h01037F64);
        add_vec("state_rd",     32'h03000004, 4'b0000, 32'h00000000, 32'h00000000, 8'hA5, 32'h01037F64);

        foreach (vq[i]) begin
            bus_xfer(vq[i].name, vq[i].addr, vq[i].wstrb, vq[i].wdata, vq[i].exp_rd);
            chk({vq[i].name, "_gpio"}, 32'(gpio_out), 32'(vq[i].exp_gpio));
            chk({vq[i].name, "_v2"}, v2_word(), vq[i].exp_v2);
        end

        // Held valid: ready pulses 1,0,1
        iomem_valid = 1'b1;
        iomem_addr  = 32'h03000000;
        iomem_wstrb = 4'b0000;
        @(posedge clk); #1;
        chk("held_ready1", 32'(iomem_ready), 32'd1);
        chk("held_rdata1", iomem_rdata, 32'h000000A5);
        @(posedge clk); #1;
        chk("held_ready2", 32'(iomem_ready), 32'd0);
        @(posedge clk); #1;
        chk("held_ready3", 32'(iomem_ready), 32'd1);
        iomem_valid = 1'b0;
        @(posedge clk); #1;

        bus_xfer("irq_en_wr", 32'h03000008 + 32'h4, 4'b0001, 32'h00000002, 32'h0);

        // Glitch shorter than the debounce window
        btn_in = 4'b0010;
        wait_cycles(3);
        btn_in = 4'b0000;
        wait_cycles(10);
        bus_xfer("glitch_state", 32'h03000004, 4'b0000, 32'h0, 32'h0);
        bus_xfer("glitch_event", 32'h03000008, 4'b0000, 32'h0, 32'h0);
        chk("glitch_irq", 32'(irq), 32'd0);

        // Held press
        btn_in = 4'b0010;
        n = 0;
        while (!irq && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("press_latency_ok", 32'(n >= 5 && n <= 6), 32'd1);
        chk("press_irq", 32'(irq), 32'd1);
        bus_xfer("press_state", 32'h03000004, 4'b0000, 32'h0, 32'h2);
        bus_xfer("press_event", 32'h03000008, 4'b0000, 32'h0, 32'h2);

        // W1C
        bus_xfer("w1c", 32'h03000008, 4'b0001, 32'h00000002, 32'h2);
        chk("w1c_irq", 32'(irq), 32'd0);
        bus_xfer("w1c_event", 32'h03000008, 4'b0000, 32'h0, 32'h0);

        // Release
        btn_in = 4'b0000;
        wait_cycles(12);
        bus_xfer("rel_state", 32'h03000004, 4'b0000, 32'h0, 32'h0);
        bus_xfer("rel_event", 32'h03000008, 4'b0000, 32'h0, REL_EVT);
        chk("rel_irq", 32'(irq), 32'd0);
        bus_xfer("rel_clr", 32'h03000008, 4'b1111, 32'hFFFFFFFF, REL_EVT);

        // W1C on the same edge as a new rise: set wins
        btn_in = 4'b0010;
        wait_cycles(5);
        chk("setwin_pre_irq", 32'(irq), 32'd0);
        bus_xfer("setwin_w1c", 32'h03000008, 4'b0001, 32'h00000002, 32'h0);
        chk("setwin_irq", 32'(irq), 32'd1);
        bus_xfer("setwin_event", 32'h03000008, 4'b0000, 32'h0, 32'h2);

        // Enable mask covers only implemented bits
        bus_xfer("en_all_wr", 32'h0300000C, 4'b1111, 32'hFFFFFFFF, 32'h2);
        bus_xfer("en_all_rd", 32'h0300000C, 4'b0000, 32'h0, EN_ALL);

`ifdef BTN_RELEASE_EVT_EN
        bus_xfer("rel2_clr", 32'h03000008, 4'b1111, 32'hFFFFFFFF, 32'h2);
        chk("rel2_irq_pre", 32'(irq), 32'd0);
        btn_in = 4'b0000;
        wait_cycles(12);
        chk("rel2_irq", 32'(irq), 32'd1);
        bus_xfer("rel2_event", 32'h03000008, 4'b0000, 32'h0, 32'h00020000);
`endif

        // Other page: no response, no state change
        iomem_valid = 1'b1;
        iomem_addr  = 32'h05000000;
        iomem_wstrb = 4'b1111;
        iomem_wdata = 32'h00000000;
        ready_cnt   = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) ready_cnt++;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        chk("page_ready_cnt", 32'(ready_cnt), 32'd0);
        chk("page_gpio", 32'(gpio_out), 32'h000000A5);
        chk("page_v2", v2_word(), 32'h01037F64);
        @(posedge clk); #1;
        bus_xfer("page_unused_rd", 32'h03000010, 4'b0000, 32'h0, 32'h0);
        bus_xfer("page_gpio_rd", 32'h03000000, 4'b0000, 32'h0, 32'h000000A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
